// File: rtl/counter_bounded.sv
// rtl/counter_bounded.sv - up/down counter held between runtime bounds, wrap or saturate
// Reports the bound it sits on, pulses wrap_o on a crossing and keeps sticky over/underflow flags.
module counter_bounded #(
   parameter int                    WORD_WIDTH    = 8,
   parameter logic [WORD_WIDTH-1:0] INCREMENT     = 'd1,
   parameter logic [WORD_WIDTH-1:0] INITIAL_COUNT = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  run_i,
   input  logic                  up_down_i,
   input  logic                  mode_i,
   input  logic                  load_i,
   input  logic [WORD_WIDTH-1:0] load_count_i,
   input  logic [WORD_WIDTH-1:0] lower_bound_i,
   input  logic [WORD_WIDTH-1:0] upper_bound_i,
   input  logic                  clear_flags_i,
   output logic [WORD_WIDTH-1:0] count_o,
   output logic                  at_upper_o,
   output logic                  at_lower_o,
   output logic                  wrap_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   // One extra bit on every sum/compare so a step past 2^W-1 or below 0 is seen as a crossing.
   logic [WORD_WIDTH:0] up_sum;
   logic [WORD_WIDTH:0] lower_plus_inc;
   logic                up_cross;
   logic                down_cross;
   logic                bounds_ok;
   logic                step_en;
   logic                set_overflow;
   logic                set_underflow;

   assign up_sum         = {1'b0, count_o} + {1'b0, INCREMENT};
   assign lower_plus_inc = {1'b0, lower_bound_i} + {1'b0, INCREMENT};
   assign up_cross       = up_sum > {1'b0, upper_bound_i};
   assign down_cross     = {1'b0, count_o} < lower_plus_inc;
   assign bounds_ok      = lower_bound_i <= upper_bound_i;
   assign step_en        = !load_i && run_i && bounds_ok;
   assign set_overflow   = step_en && !up_down_i && up_cross;
   assign set_underflow  = step_en && up_down_i && down_cross;

   assign at_upper_o = count_o == upper_bound_i;
   assign at_lower_o = count_o == lower_bound_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_o     <= INITIAL_COUNT;
         wrap_o      <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (load_i) begin
            count_o <= load_count_i;
            wrap_o  <= 1'b0;
         end else if (step_en) begin
            if (!up_down_i) begin
               if (up_cross) begin
                  count_o <= mode_i ? upper_bound_i : lower_bound_i;
                  wrap_o  <= 1'b1;
               end else begin
                  count_o <= up_sum[WORD_WIDTH-1:0];
                  wrap_o  <= 1'b0;
               end
            end else begin
               if (down_cross) begin
                  count_o <= mode_i ? lower_bound_i : upper_bound_i;
                  wrap_o  <= 1'b1;
               end else begin
                  count_o <= count_o - INCREMENT;
                  wrap_o  <= 1'b0;
               end
            end
         end else begin
            wrap_o <= 1'b0;
         end

         // A crossing in the same cycle as a clear keeps its flag set.
         overflow_o  <= set_overflow  || (overflow_o  && !clear_flags_i);
         underflow_o <= set_underflow || (underflow_o && !clear_flags_i);
      end
   end

endmodule

// File: tb/tb_counter_bounded.sv
// tb/tb_counter_bounded.sv - randomized and directed bench for counter_bounded against an arithmetic model
// Two instances (INC=1/INIT=9 and INC=3/INIT=0) share all inputs.
module tb_counter_bounded;

   logic       clk_i = 1'b0;
   logic       rst_ni, run_i, up_down_i, mode_i, load_i, clear_flags_i;
   logic [7:0] load_count_i, lower_bound_i, upper_bound_i;

   logic [7:0] cnt_a, cnt_b;
   logic       upper_a, lower_a, wrap_a, ovf_a, unf_a;
   logic       upper_b, lower_b, wrap_b, ovf_b, unf_b;

   int errors = 0;
   int checks = 0;

   int m_cnt [2];
   int m_wrap[2];
   int m_ovf [2];
   int m_unf [2];
   int m_inc [2] = '{1, 3};
   int m_init[2] = '{9, 0};

   always #5 clk_i = ~clk_i;

   counter_bounded #(.WORD_WIDTH(8), .INCREMENT(8'd1), .INITIAL_COUNT(8'd9)) dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .up_down_i(up_down_i), .mode_i(mode_i),
      .load_i(load_i), .load_count_i(load_count_i), .lower_bound_i(lower_bound_i),
      .upper_bound_i(upper_bound_i), .clear_flags_i(clear_flags_i), .count_o(cnt_a),
      .at_upper_o(upper_a), .at_lower_o(lower_a), .wrap_o(wrap_a), .overflow_o(ovf_a),
      .underflow_o(unf_a));

   counter_bounded #(.WORD_WIDTH(8), .INCREMENT(8'd3), .INITIAL_COUNT(8'd0)) dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .up_down_i(up_down_i), .mode_i(mode_i),
      .load_i(load_i), .load_count_i(load_count_i), .lower_bound_i(lower_bound_i),
      .upper_bound_i(upper_bound_i), .clear_flags_i(clear_flags_i), .count_o(cnt_b),
      .at_upper_o(upper_b), .at_lower_o(lower_b), .wrap_o(wrap_b), .overflow_o(ovf_b),
      .underflow_o(unf_b));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = m_init[i];
         m_wrap[i] = 0;
         m_ovf[i] = 0;
         m_unf[i] = 0;
      end
   endtask

   // Reference: the rules applied with plain integer arithmetic on the sampled inputs.
   task automatic model_edge();
      int lo, hi;
      lo = int'(lower_bound_i);
      hi = int'(upper_bound_i);
      for (int i = 0; i < 2; i++) begin
         int ov, un;
         ov = (clear_flags_i) ? 0 : m_ovf[i];
         un = (clear_flags_i) ? 0 : m_unf[i];
         if (load_i) begin
            m_cnt[i] = int'(load_count_i);
            m_wrap[i] = 0;
         end else if (run_i && lo <= hi) begin
            if (!up_down_i) begin
               if (m_cnt[i] + m_inc[i] > hi) begin
                  m_cnt[i] = mode_i ? hi : lo;
                  m_wrap[i] = 1;
                  ov = 1;
               end else begin
                  m_cnt[i] = m_cnt[i] + m_inc[i];
                  m_wrap[i] = 0;
               end
            end else begin
               if (m_cnt[i] < lo + m_inc[i]) begin
                  m_cnt[i] = mode_i ? lo : hi;
                  m_wrap[i] = 1;
                  un = 1;
               end else begin
                  m_cnt[i] = m_cnt[i] - m_inc[i];
                  m_wrap[i] = 0;
               end
            end
         end else begin
            m_wrap[i] = 0;
         end
         m_ovf[i] = ov;
         m_unf[i] = un;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".a.count"}, int'(cnt_a), m_cnt[0]);
      check({tag, ".a.wrap"}, int'(wrap_a), m_wrap[0]);
      check({tag, ".a.ovf"}, int'(ovf_a), m_ovf[0]);
      check({tag, ".a.unf"}, int'(unf_a), m_unf[0]);
      check({tag, ".a.at_upper"}, int'(upper_a), int'(m_cnt[0] == int'(upper_bound_i)));
      check({tag, ".a.at_lower"}, int'(lower_a), int'(m_cnt[0] == int'(lower_bound_i)));
      check({tag, ".b.count"}, int'(cnt_b), m_cnt[1]);
      check({tag, ".b.wrap"}, int'(wrap_b), m_wrap[1]);
      check({tag, ".b.ovf"}, int'(ovf_b), m_ovf[1]);
      check({tag, ".b.unf"}, int'(unf_b), m_unf[1]);
      check({tag, ".b.at_upper"}, int'(upper_b), int'(m_cnt[1] == int'(upper_bound_i)));
      check({tag, ".b.at_lower"}, int'(lower_b), int'(m_cnt[1] == int'(lower_bound_i)));
   endtask

   task automatic step(input string tag);
      @(posedge clk_i);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic set_in(input logic ld, input logic [7:0] lc, input logic run, input logic ud,
                         input logic md, input logic [7:0] lo, input logic [7:0] hi,
                         input logic clr);
      load_i = ld;
      load_count_i = lc;
      run_i = run;
      up_down_i = ud;
      mode_i = md;
      lower_bound_i = lo;
      upper_bound_i = hi;
      clear_flags_i = clr;
   endtask

   int exp_a[5] = '{3, 4, 5, 2, 3};
   int exp_b[4] = '{4, 1, 0, 0};
   int flag_before;

   initial begin
      rst_ni = 1'b0;
      set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
      model_reset();
      #12;
      check("reset.a.count", int'(cnt_a), 9);
      check("reset.b.count", int'(cnt_b), 0);
      check_all("reset");
      rst_ni = 1'b1;

      // Wrap mode, bounds 2..5, counting up from 2.
      set_in(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 8'd5, 1'b0);
      step("A.load");
      set_in(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd5, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step("A.run");
         check("A.seq.count", int'(cnt_a), exp_a[k]);
         check("A.seq.wrap", int'(wrap_a), (k == 3) ? 1 : 0);
         check("A.seq.ovf", int'(ovf_a), (k >= 3) ? 1 : 0);
      end

      // Saturate mode, INC=3, bounds 0..10, counting down from 7.
      set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd10, 1'b1);
      step("B.clear");
      set_in(1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 8'd0, 8'd10, 1'b0);
      step("B.load");
      set_in(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd10, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step("B.run");
         check("B.seq.count", int'(cnt_b), exp_b[k]);
         check("B.seq.wrap", int'(wrap_b), (k >= 2) ? 1 : 0);
         check("B.seq.unf", int'(unf_b), (k >= 2) ? 1 : 0);
      end

      // Out-of-bounds load beats run, then the next up step crosses.
      set_in(1'b1, 8'd20, 1'b1, 1'b0, 1'b0, 8'd0, 8'd10, 1'b0);
      step("C.load");
      check("C.load.a", int'(cnt_a), 20);
      check("C.load.b", int'(cnt_b), 20);
      set_in(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd10, 1'b0);
      step("C.up");
      check("C.up.count", int'(cnt_a), 0);
      check("C.up.ovf", int'(ovf_a), 1);

      // Clear against a simultaneous crossing.
      set_in(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd0, 8'd10, 1'b0);
      step("D.load");
      set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd10, 1'b1);
      step("D.clear");
      check("D.clear.ovf", int'(ovf_a), 0);
      set_in(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd10, 1'b1);
      step("D.cross");
      check("D.cross.ovf", int'(ovf_a), 1);
      set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd10, 1'b1);
      step("D.clear2");
      check("D.clear2.ovf", int'(ovf_a), 0);

      // Full range in wrap mode behaves as a modular counter but still flags.
      set_in(1'b1, 8'd254, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
      step("E.load");
      set_in(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
      step("E.255");
      check("E.255.count", int'(cnt_a), 255);
      step("E.0");
      check("E.0.count", int'(cnt_a), 0);
      check("E.0.wrap", int'(wrap_a), 1);
      check("E.0.ovf", int'(ovf_a), 1);

      // Asynchronous reset between edges.
      #3 rst_ni = 1'b0;
      #1;
      model_reset();
      check("R.async.count", int'(cnt_a), 9);
      check("R.async.ovf", int'(ovf_a), 0);
      check_all("R.async");
      #2 rst_ni = 1'b1;
      step("R.resume");
      check("R.resume.a", int'(cnt_a), 10);
      check("R.resume.b", int'(cnt_b), 3);

      // Swapped bounds: counter and flags hold.
      set_in(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, 1'b0);
      step("F.load");
      flag_before = int'(ovf_a);
      set_in(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd8, 8'd3, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step("F.hold");
         check("F.hold.count", int'(cnt_a), 6);
         check("F.hold.ovf", int'(ovf_a), flag_before);
         check("F.hold.wrap", int'(wrap_a), 0);
      end

      // Random legal traffic with bounds changing on the fly.
      for (int n = 0; n < 400; n++) begin
         logic [7:0] lo, hi, lc;
         logic       ld, clr;
         lo = 8'($urandom_range(0, 255));
         hi = 8'($urandom_range(int'(lo), 255));
         if ($urandom_range(0, 9) == 0) begin
            lo = 8'd0;
            hi = 8'd255;
         end
         lc  = 8'($urandom_range(0, 255));
         ld  = ($urandom_range(0, 7) == 0);
         clr = !ld && ($urandom_range(0, 9) == 0);
         set_in(ld, lc, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), lo, hi, clr);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
